// File: rtl/player_key_decoder.sv
// PS/2 set-2 scancode decoder for player controls: held-key levels for left/right/jump and a respawn pulse on ESC.
// Optional ARROW_KEYS_EN adds the extended arrow keys (E0 6B / 74 / 75) to the movement outputs.
module player_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1_300_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       left,
    output logic       right,
    output logic       jump,
    output logic       reset
);

    localparam int unsigned CNT_W = 21;
    localparam int unsigned K_A   = 0;
    localparam int unsigned K_D   = 1;
    localparam int unsigned K_W   = 2;
    localparam int unsigned K_SP  = 3;
    localparam int unsigned K_ESC = 4;
`ifdef ARROW_KEYS_EN
    localparam int unsigned K_LA     = 5;
    localparam int unsigned K_RA     = 6;
    localparam int unsigned K_UA     = 7;
    localparam int unsigned NUM_KEYS = 8;
`else
    localparam int unsigned NUM_KEYS = 5;
`endif

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]  held_q, held_d;
    logic [NUM_KEYS-1:0]  base_hit;
    logic                 pulse_d;
    logic                 left_d, right_d, jump_d;
`ifdef ARROW_KEYS_EN
    logic [NUM_KEYS-1:0]  ext_hit;
`endif

    // One-hot match of a non-extended scancode against the tracked keys
    always_comb begin
        base_hit = '0;
        case (rx_data)
            8'h1C:   base_hit[K_A]   = 1'b1;
            8'h23:   base_hit[K_D]   = 1'b1;
            8'h1D:   base_hit[K_W]   = 1'b1;
            8'h29:   base_hit[K_SP]  = 1'b1;
            8'h76:   base_hit[K_ESC] = 1'b1;
            default: ;
        endcase
    end

`ifdef ARROW_KEYS_EN
    always_comb begin
        ext_hit = '0;
        case (rx_data)
            8'h6B:   ext_hit[K_LA] = 1'b1;
            8'h74:   ext_hit[K_RA] = 1'b1;
            8'h75:   ext_hit[K_UA] = 1'b1;
            default: ;
        endcase
    end
`endif

    // Next-state, timeout and held-flag update; a received byte always wins over the timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        pulse_d = 1'b0;
        if (rx_valid) begin
            cnt_d   = '0;
            state_d = IDLE;
            unique case (state_q)
                IDLE: begin
                    if (rx_data == 8'hF0) begin
                        state_d = BRK;
                    end else if (rx_data == 8'hE0) begin
                        state_d = EXT;
                    end else begin
                        held_d  = held_q | base_hit;
                        pulse_d = base_hit[K_ESC] & ~held_q[K_ESC];
                    end
                end
                BRK: held_d = held_q & ~base_hit;
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = EXT_BRK;
                    end
`ifdef ARROW_KEYS_EN
                    else begin
                        held_d = held_q | ext_hit;
                    end
`endif
                end
                EXT_BRK: begin
`ifdef ARROW_KEYS_EN
                    held_d = held_q & ~ext_hit;
`endif
                end
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
`ifdef ARROW_KEYS_EN
        left_d  = held_d[K_A] | held_d[K_LA];
        right_d = held_d[K_D] | held_d[K_RA];
        jump_d  = held_d[K_W] | held_d[K_SP] | held_d[K_UA];
`else
        left_d  = held_d[K_A];
        right_d = held_d[K_D];
        jump_d  = held_d[K_W] | held_d[K_SP];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
            left    <= 1'b0;
            right   <= 1'b0;
            jump    <= 1'b0;
            reset   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            left    <= left_d;
            right   <= right_d;
            jump    <= jump_d;
            reset   <= pulse_d;
        end
    end

endmodule

// File: tb/tb_player_key_decoder.sv
// Self-checking bench for player_key_decoder: directed scenarios then a random scancode stream vs a key-set model.
module tb_player_key_decoder;

    localparam int unsigned T = 16;
`ifdef ARROW_KEYS_EN
    localparam bit ARROWS = 1'b1;
`else
    localparam bit ARROWS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       left, right, jump, reset;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: sets of held base/extended codes plus pending prefix flags
    bit [255:0] m_held;
    bit [255:0] m_xheld;
    bit         m_brk, m_ext;
    bit         m_pulse;

    player_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .left     (left),
        .right    (right),
        .jump     (jump),
        .reset    (reset)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_held = '0; m_xheld = '0; m_brk = 0; m_ext = 0; m_pulse = 0;
    endfunction

    // k = cycles since the previous byte strobe; a prefix survives k <= T
    function automatic void model_step(input logic [7:0] b, input int k);
        if ((m_brk || m_ext) && k > T) begin
            m_brk = 0; m_ext = 0;
        end
        m_pulse = 0;
        if (!m_brk && !m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else begin
                if (b == 8'h76 && !m_held[8'h76]) m_pulse = 1;
                m_held[b] = 1;
            end
        end else if (m_brk && !m_ext) begin
            m_held[b] = 0;
            m_brk = 0;
        end else if (!m_brk && m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else begin
                m_xheld[b] = 1;
                m_ext = 0;
            end
        end else begin
            m_xheld[b] = 0;
            m_brk = 0; m_ext = 0;
        end
    endfunction

    function automatic logic exp_left();
        return m_held[8'h1C] | (ARROWS & m_xheld[8'h6B]);
    endfunction
    function automatic logic exp_right();
        return m_held[8'h23] | (ARROWS & m_xheld[8'h74]);
    endfunction
    function automatic logic exp_jump();
        return m_held[8'h1D] | m_held[8'h29] | (ARROWS & m_xheld[8'h75]);
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".left"},  left,  exp_left());
        check_eq({tag, ".right"}, right, exp_right());
        check_eq({tag, ".jump"},  jump,  exp_jump());
        check_eq({tag, ".reset"}, reset, m_pulse);
    endtask

    // Called at posedge+1; idles g cycles, strobes one byte, checks one cycle later
    task automatic send(input logic [7:0] b, input int g, input string tag);
        for (int i = 0; i < g; i++) begin
            @(posedge clk); #1;
            if (i == 0) check_eq({tag, ".pulse_end"}, reset, 1'b0);
        end
        model_step(b, g + 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs("after_reset");
    endtask

    logic [7:0] pool [12] = '{8'h1C, 8'h23, 8'h1D, 8'h29, 8'h76, 8'hF0,
                              8'hE0, 8'h6B, 8'h74, 8'h75, 8'h12, 8'h5A};

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        #1;
        do_reset();

        // A make and break
        send(8'h1C, 1, "a_make");
        send(8'hF0, 1, "a_brk_pfx");
        send(8'h1C, 1, "a_brk");

        // Space and W share jump
        send(8'h29, 1, "sp_make");
        send(8'h1D, 1, "w_make");
        send(8'hF0, 1, "sp_brk_pfx");
        send(8'h29, 1, "sp_brk");
        send(8'hF0, 0, "w_brk_pfx");
        send(8'h1D, 0, "w_brk");

        // ESC typematic pulses once; new press after break pulses again
        send(8'h76, 2, "esc1");
        send(8'h76, 2, "esc2");
        send(8'h76, 2, "esc3");
        send(8'hF0, 2, "esc_brk_pfx");
        send(8'h76, 2, "esc_brk");
        send(8'h76, 2, "esc4");

        // Prefix timeout: after T idle cycles the 23 is a make
        send(8'hF0, 1, "to_pfx");
        send(8'h23, T, "to_make");
        // Prefix still alive at T-1 idle cycles: 23 is a break
        send(8'hF0, 1, "live_pfx");
        send(8'h23, T - 1, "live_brk");

        // Extended right arrow make/break; then plain D
        send(8'hE0, 1, "ra_e0");
        send(8'h74, 1, "ra_make");
        send(8'hE0, 1, "ra_brk_e0");
        send(8'hF0, 1, "ra_brk_f0");
        send(8'h74, 1, "ra_brk");
        send(8'h23, 1, "d_make");
        send(8'hF0, 1, "d_brk_pfx");
        send(8'h23, 1, "d_brk");

        // Asynchronous reset mid-sequence while A held
        send(8'h1C, 1, "ar_make");
        send(8'hF0, 1, "ar_pfx");
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h1C, 1, "ar_after");

        // Random scancode stream with gaps around the timeout boundary
        for (int n = 0; n < 400; n++) begin
            int g;
            logic [7:0] b;
            b = pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) g = int'($urandom_range(T - 2, T + 1));
            else g = int'($urandom_range(0, 3));
            send(b, g, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_key_decoder.md
PLAYER_KEY_DECODER -- requirements
Module: player_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_300_000, the number of clk cycles (20 ms at 65 MHz) a prefix state waits for the next byte before abandoning the sequence.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx_data  input  8  PS/2 set-2 scancode byte from the PS/2 receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data is valid only in a cycle where rx_valid=1.
REQ-006 SHALL have port left  output  1  level; high while a left key is held.
REQ-007 SHALL have port right  output  1  level; high while a right key is held.
REQ-008 SHALL have port jump  output  1  level; high while a jump key is held.
REQ-009 SHALL have port reset  output  1  one-cycle pulse requesting a player respawn.

Function
REQ-010 SHALL implement an FSM with states IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 F0).
REQ-011 SHALL make these transitions, each taken only on a byte accepted with rx_valid=1:
- IDLE + F0 -> BRK
- IDLE + E0 -> EXT
- EXT + F0 -> EXT_BRK
- any other byte completes a sequence and returns the FSM to IDLE.
REQ-012 SHALL hold an independent held-flag for each key: A (1C), D (23), W (1D), Space (29).
REQ-013 SHALL set the matching held-flag on a make code in IDLE and clear it on the same code in BRK.
REQ-014 SHALL drive left=A held, right=D held, and jump=W held OR Space held.
REQ-015 SHALL pulse reset high for exactly one cycle on the make of ESC (76) in IDLE. An ESC break and an auto-repeated ESC make within a single hold SHALL NOT pulse again; a held-flag for ESC is kept for this purpose.
REQ-016 SHALL update every output on the clk edge after the completing byte's rx_valid cycle (latency 1).
REQ-017 SHALL register all outputs; there is no combinational path from rx_data or rx_valid to any output.
REQ-018 SHALL leave state unchanged for unrecognised codes except that the FSM returns to IDLE; no flag changes.
REQ-019 SHALL treat a repeated make of an already-held key (typematic) as a no-op.
REQ-020 SHALL report left and right both high when both are held; arbitration is left to the movement controller.
REQ-021 SHALL run a 21-bit timeout counter as follows:
- cleared on every accepted byte;
- counts only while the FSM is in BRK, EXT or EXT_BRK;
- on reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE with no flag change.
REQ-022 SHALL give rx_valid in the timeout cycle priority over the timeout.
REQ-023 SHALL ignore rx_data whenever rx_valid=0.

Reset
REQ-024 SHALL, on rst high and asynchronously, force the FSM to IDLE, clear the counter and all held-flags, and drive left, right, jump and reset to 0.
REQ-025 SHALL discard a sequence in progress when rst asserts mid-sequence; the first byte after release is decoded from IDLE.

Configuration
REQ-026 SHALL, with ARROW_KEYS_EN defined, additionally map the extended keys E0 6B (left arrow), E0 74 (right arrow) and E0 75 (up arrow).
- left = A held OR left-arrow held.
- right = D held OR right-arrow held.
- jump = W held OR Space held OR up-arrow held.
- Arrow makes are decoded in EXT; arrow breaks are decoded in EXT_BRK.
REQ-027 SHALL, without ARROW_KEYS_EN, include no arrow flags. Extended sequences are still parsed through EXT/EXT_BRK so that they are swallowed, and they affect no output.

Verification
REQ-028 Bytes 1C, then F0 1C -> left=1 one cycle after the 1C strobe; left=0 one cycle after the second 1C strobe; right and jump stay 0 throughout.
REQ-029 Bytes 29 then 1D, then F0 29 -> jump=1 after 29 and stays 1 after the break because W is still held; F0 1D -> jump=0.
REQ-030 Bytes 76 76 76 -> reset is high for exactly one cycle in total; after F0 76 then 76, a second single pulse occurs.
REQ-031 Byte F0, then no byte for TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=16 in simulation), then 23 -> right=1, because the 23 is decoded as a make and not a break.
REQ-032 With ARROW_KEYS_EN: E0 74 -> right=1, then E0 F0 74 -> right=0. Without it, the same bytes leave right=0; a following 23 -> right=1.
REQ-033 rst asserted between F0 and 1C while left=1 -> left=0 immediately (asynchronously); 1C after release -> left=1.
